// File: rtl/data_c_wrr_pkt_arbiter.sv
// Packet-atomic weighted round-robin arbiter for an N-to-1 data_inf_c stream merge.
// Holds a registered one-hot grant per packet, with per-source packet quanta and a mid-packet watchdog.
module data_c_wrr_pkt_arbiter #(
    parameter int unsigned NUM   = 4,
    parameter int unsigned NSIZE = (NUM > 1) ? $clog2(NUM) : 1,
    parameter int unsigned WSIZE = 4,
    parameter int unsigned TMO   = 0
) (
    input  logic                   clock,
    input  logic                   rst_n,
    input  logic [NUM*WSIZE-1:0]   weight,
    input  logic [NUM-1:0]         enable,
    input  logic [NUM-1:0]         req_valid,
    input  logic [NUM-1:0]         req_last,
    input  logic                   down_ready,
    output logic [NUM-1:0]         grant,
    output logic [NSIZE-1:0]       grant_path,
    output logic                   grant_vld,
    output logic                   timeout_err,
    output logic [NSIZE-1:0]       err_path
);

    localparam int unsigned   CW       = 16;
    localparam bit            WD_EN    = (TMO != 0);
    localparam logic [CW-1:0] TMO_LAST = CW'(TMO - 1);

    typedef enum logic {IDLE, PKT} state_t;

    state_t             state_q, state_d;
    logic [NSIZE-1:0]   last_q, last_d;
    logic [WSIZE-1:0]   credit_q, credit_d;
    logic [CW-1:0]      idle_q, idle_d;
    logic [NUM-1:0]     grant_d;
    logic [NSIZE-1:0]   path_d;
    logic               vld_d;
    logic               tmo_d;
    logic [NSIZE-1:0]   errp_d;

    logic [WSIZE-1:0]   wt [NUM];
    logic [NUM-1:0]     elig;
    logic               found;
    logic [NSIZE-1:0]   rr_idx;
    logic               eop;
    logic               expire;

    // Per-source weight unpack and eligibility.
    always_comb begin
        for (int i = 0; i < int'(NUM); i++) begin
            wt[i]   = weight[i*WSIZE +: WSIZE];
            elig[i] = req_valid[i] & enable[i] & (weight[i*WSIZE +: WSIZE] != '0);
        end
    end

    // First eligible source after last_q, wrapping; last_q itself is checked last.
    always_comb begin : rr_search
        int               sum;
        logic [NSIZE-1:0] cand;
        found  = 1'b0;
        rr_idx = '0;
        sum    = 0;
        cand   = '0;
        for (int k = 1; k <= int'(NUM); k++) begin
            sum = int'(last_q) + k;
            if (sum >= int'(NUM)) begin
                sum = sum - int'(NUM);
            end
            cand = NSIZE'(sum);
            if (!found && elig[cand]) begin
                found  = 1'b1;
                rr_idx = cand;
            end
        end
    end

    assign eop    = grant_vld & req_valid[grant_path] & down_ready & req_last[grant_path];
    assign expire = WD_EN && (state_q == PKT) && !req_valid[grant_path] && (idle_q == TMO_LAST);

    // Next-state, select and watchdog logic.
    always_comb begin : fsm_next
        logic             do_sel;
        logic [WSIZE-1:0] credit_eff;
        logic [NSIZE-1:0] win;
        state_d    = state_q;
        last_d     = last_q;
        credit_d   = credit_q;
        idle_d     = idle_q;
        grant_d    = grant;
        path_d     = grant_path;
        vld_d      = grant_vld;
        tmo_d      = 1'b0;
        errp_d     = err_path;
        do_sel     = 1'b0;
        credit_eff = credit_q;
        win        = last_q;

        case (state_q)
            IDLE: begin
                idle_d = '0;
                if (found) begin
                    do_sel = 1'b1;
                end
            end
            PKT: begin
                if (eop) begin
                    do_sel = 1'b1;
                end else if (expire) begin
                    do_sel     = 1'b1;
                    credit_eff = '0;
                    tmo_d      = 1'b1;
                    errp_d     = grant_path;
                end else if (WD_EN) begin
                    idle_d = req_valid[grant_path] ? '0 : idle_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (do_sel) begin
            idle_d   = '0;
            credit_d = credit_eff;
            if (found) begin
                if ((credit_eff != '0) && elig[last_q]) begin
                    win      = last_q;
                    credit_d = credit_eff - WSIZE'(1);
                end else begin
                    win      = rr_idx;
                    credit_d = wt[rr_idx] - WSIZE'(1);
                    last_d   = rr_idx;
                end
                grant_d      = '0;
                grant_d[win] = 1'b1;
                path_d       = win;
                vld_d        = 1'b1;
                state_d      = PKT;
            end else begin
                grant_d = '0;
                path_d  = '0;
                vld_d   = 1'b0;
                state_d = IDLE;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_q      <= NSIZE'(NUM - 1);
            credit_q    <= '0;
            idle_q      <= '0;
            grant       <= '0;
            grant_path  <= '0;
            grant_vld   <= 1'b0;
            timeout_err <= 1'b0;
            err_path    <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            credit_q    <= credit_d;
            idle_q      <= idle_d;
            grant       <= grant_d;
            grant_path  <= path_d;
            grant_vld   <= vld_d;
            timeout_err <= tmo_d;
            err_path    <= errp_d;
        end
    end

endmodule

// File: tb/tb_data_c_wrr_pkt_arbiter.sv
// Scoreboard bench for data_c_wrr_pkt_arbiter: expected packet-end grants and watchdog events
// are queued by the stimulus and checked by an independent negedge monitor.
module tb_data_c_wrr_pkt_arbiter;

    localparam int unsigned NUM   = 4;
    localparam int unsigned NSIZE = 2;
    localparam int unsigned WSIZE = 4;
    localparam int unsigned TMO   = 8;

    logic                 clock;
    logic                 rst_n;
    logic [NUM*WSIZE-1:0] weight;
    logic [NUM-1:0]       enable;
    logic [NUM-1:0]       req_valid;
    logic [NUM-1:0]       req_last;
    logic                 down_ready;
    logic [NUM-1:0]       grant;
    logic [NSIZE-1:0]     grant_path;
    logic                 grant_vld;
    logic                 timeout_err;
    logic [NSIZE-1:0]     err_path;

    data_c_wrr_pkt_arbiter #(
        .NUM   (NUM),
        .NSIZE (NSIZE),
        .WSIZE (WSIZE),
        .TMO   (TMO)
    ) dut (
        .clock       (clock),
        .rst_n       (rst_n),
        .weight      (weight),
        .enable      (enable),
        .req_valid   (req_valid),
        .req_last    (req_last),
        .down_ready  (down_ready),
        .grant       (grant),
        .grant_path  (grant_path),
        .grant_vld   (grant_vld),
        .timeout_err (timeout_err),
        .err_path    (err_path)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int exp_q[$];
    int tmo_err_q[$];
    int tmo_nxt_q[$];
    int eop_t[$];
    int tmo_cyc = 0;
    int mon_e;

    // Source models
    int len[NUM];
    int left[NUM];
    int beat[NUM];
    bit stall[NUM];
    int stall_beat = 0;
    bit toggle_rdy = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired, %0d eops and %0d timeouts outstanding",
                 name, exp_q.size(), tmo_err_q.size());
        exp_q.delete();
        tmo_err_q.delete();
        tmo_nxt_q.delete();
    endtask

    // Monitor: packet ends and watchdog pulses
    always @(negedge clock) begin
        if (rst_n) begin
            if (grant_vld && req_valid[grant_path] && down_ready && req_last[grant_path]) begin
                eop_t.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("unexpected_eop", int'(grant_path), -1);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("eop_path", int'(grant_path), mon_e);
                    check("eop_grant", int'(grant), 1 << mon_e);
                end
            end
            if (timeout_err) begin
                tmo_cyc = cyc;
                if (tmo_err_q.size() == 0) begin
                    check("unexpected_timeout", int'(err_path), -1);
                end else begin
                    check("tmo_err_path", int'(err_path), tmo_err_q.pop_front());
                    check("tmo_next_path", int'(grant_path), tmo_nxt_q[0]);
                    check("tmo_next_grant", int'(grant), 1 << tmo_nxt_q.pop_front());
                end
            end
        end
    end

    task automatic drive();
        for (int i = 0; i < int'(NUM); i++) begin
            req_valid[i] = (left[i] > 0) && !(stall[i] && beat[i] == stall_beat);
            req_last[i]  = (beat[i] == len[i] - 1);
        end
    endtask

    task automatic set_weights(input int w0, input int w1, input int w2, input int w3);
        weight = {WSIZE'(w3), WSIZE'(w2), WSIZE'(w1), WSIZE'(w0)};
    endtask

    // One clock: sample transfers at negedge, advance sources just after posedge.
    task automatic tick();
        logic [NUM-1:0] xf;
        @(negedge clock);
        xf = grant & req_valid & {NUM{down_ready}};
        @(posedge clock);
        #1;
        for (int i = 0; i < int'(NUM); i++) begin
            if (xf[i]) begin
                if (beat[i] == len[i] - 1) begin
                    beat[i] = 0;
                    left[i] = left[i] - 1;
                end else begin
                    beat[i] = beat[i] + 1;
                end
            end
        end
        if (toggle_rdy) down_ready = ~down_ready;
        drive();
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || tmo_err_q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0 || tmo_err_q.size() != 0) bound_fail(name);
    endtask

    // Asynchronous reset: outputs must clear before the next clock edge.
    task automatic do_reset();
        @(negedge clock);
        rst_n = 1'b0;
        #1;
        check("rst_grant", int'(grant), 0);
        check("rst_grant_path", int'(grant_path), 0);
        check("rst_grant_vld", int'(grant_vld), 0);
        check("rst_timeout_err", int'(timeout_err), 0);
        check("rst_err_path", int'(err_path), 0);
        for (int i = 0; i < int'(NUM); i++) begin
            left[i]  = 0;
            beat[i]  = 0;
            stall[i] = 1'b0;
            len[i]   = 1;
        end
        enable     = '1;
        toggle_rdy = 1'b0;
        down_ready = 1'b1;
        drive();
        exp_q.delete();
        tmo_err_q.delete();
        tmo_nxt_q.delete();
        eop_t.delete();
        repeat (2) @(posedge clock);
        @(negedge clock);
        rst_n = 1'b1;
        @(posedge clock);
        #1;
    endtask

    initial begin
        int n;
        int bad;
        int d_cyc;
        int g3;

        rst_n      = 1'b0;
        enable     = '1;
        down_ready = 1'b1;
        set_weights(1, 1, 1, 1);
        for (int i = 0; i < int'(NUM); i++) begin
            left[i] = 0; beat[i] = 0; stall[i] = 1'b0; len[i] = 1;
        end
        drive();
        repeat (3) @(posedge clock);
        #1;
        check("init_grant", int'(grant), 0);
        check("init_grant_vld", int'(grant_vld), 0);
        check("init_timeout_err", int'(timeout_err), 0);
        @(negedge clock);
        rst_n = 1'b1;
        @(posedge clock);
        #1;

        // Equal weights, 2-beat packets from all sources: 0,1,2,3,0,1,2,3 with no bubbles
        set_weights(1, 1, 1, 1);
        for (int i = 0; i < int'(NUM); i++) begin len[i] = 2; left[i] = 2; end
        foreach (exp_q[i]) exp_q.delete(i);
        for (int r = 0; r < 2; r++) for (int i = 0; i < int'(NUM); i++) exp_q.push_back(i);
        eop_t.delete();
        drive();
        drain("rr_equal", 60);
        check("rr_eop_count", eop_t.size(), 8);
        if (eop_t.size() == 8) check("rr_no_bubble_span", eop_t[7] - eop_t[0], 14);
        do_reset();

        // Weights {3,1,1,1}, 1-beat packets
        set_weights(3, 1, 1, 1);
        len = '{1, 1, 1, 1};
        left = '{6, 1, 1, 1};
        begin
            int seq[9] = '{0, 0, 0, 1, 2, 3, 0, 0, 0};
            foreach (seq[i]) exp_q.push_back(seq[i]);
        end
        drive();
        drain("wrr_quantum", 60);
        do_reset();

        // Lone source 2, 3-beat packets, downstream ready toggling
        set_weights(1, 1, 1, 1);
        len[2] = 3;
        left[2] = 3;
        toggle_rdy = 1'b1;
        repeat (3) exp_q.push_back(2);
        drive();
        n = 0;
        bad = 0;
        while (exp_q.size() != 0 && n < 80) begin
            tick();
            n++;
            if (!grant_vld || grant_path != NSIZE'(2)) bad++;
        end
        if (exp_q.size() != 0) bound_fail("lone_src");
        check("lone_grant_held", bad, 0);
        do_reset();

        // Watchdog: source 1 stalls after two beats; grant moves to source 3
        set_weights(1, 1, 1, 1);
        len[1] = 4; left[1] = 1; stall[1] = 1'b1; stall_beat = 2;
        len[3] = 4; left[3] = 1;
        tmo_err_q.push_back(1);
        tmo_nxt_q.push_back(3);
        exp_q.push_back(3);
        drive();
        n = 0;
        while (req_valid[1] && n < 20) begin
            tick();
            n++;
        end
        if (req_valid[1]) bound_fail("wd_stall");
        d_cyc = cyc;
        check("wd_held_path", int'(grant_path), 1);
        drain("watchdog", 40);
        check("wd_latency", tmo_cyc - d_cyc, 8);
        check("wd_err_path_hold", int'(err_path), 1);
        check("wd_pulse_low", int'(timeout_err), 0);
        do_reset();

        // enable[0] dropped mid-packet, weight[3]=0
        set_weights(2, 1, 1, 0);
        len = '{2, 2, 2, 2};
        left = '{2, 1, 1, 2};
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(0);
        drive();
        n = 0;
        g3 = 0;
        while (!grant_vld && n < 10) begin
            tick();
            n++;
        end
        check("en_first_grant", int'(grant_path), 0);
        enable[0] = 1'b0;
        while (exp_q.size() > 2 && n < 50) begin
            tick();
            n++;
            if (grant[3]) g3++;
        end
        enable[0] = 1'b1;
        while (exp_q.size() != 0 && n < 60) begin
            tick();
            n++;
            if (grant[3]) g3++;
        end
        if (exp_q.size() != 0) bound_fail("enable_mask");
        check("zero_weight_never_granted", g3, 0);
        do_reset();

        // Reset mid-packet, then sources 0 and 1: source 0 first
        set_weights(1, 1, 1, 1);
        len[0] = 4; left[0] = 1;
        len[1] = 4; left[1] = 1;
        drive();
        n = 0;
        while (!grant_vld && n < 10) begin
            tick();
            n++;
        end
        tick();
        check("pre_reset_vld", int'(grant_vld), 1);
        do_reset();
        set_weights(1, 1, 1, 1);
        len[0] = 4; left[0] = 1;
        len[1] = 4; left[1] = 1;
        exp_q.push_back(0);
        exp_q.push_back(1);
        drive();
        drain("post_reset", 40);
        do_reset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
